// File: rtl/loop_nest_counter.sv
// Three-level (column -> row -> tile) loop-nest index generator for the systolic
// matmul datapath, with start/busy/done job control and an advance/stall input.
module loop_nest_counter #(
    parameter  int MAX_COLS  = 32,
    parameter  int MAX_ROWS  = 32,
    parameter  int MAX_TILES = 16,
    localparam int CW  = (MAX_COLS  > 1) ? $clog2(MAX_COLS)  : 1,
    localparam int RW  = (MAX_ROWS  > 1) ? $clog2(MAX_ROWS)  : 1,
    localparam int TW  = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1,
    localparam int CCW = $clog2(MAX_COLS + 1),
    localparam int RCW = $clog2(MAX_ROWS + 1),
    localparam int TCW = $clog2(MAX_TILES + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [CCW-1:0] cfg_cols,
    input  logic [RCW-1:0] cfg_rows,
    input  logic [TCW-1:0] cfg_tiles,
    input  logic           advance,
    output logic [CW-1:0]  col_cntr,
    output logic [RW-1:0]  row_cntr,
    output logic [TW-1:0]  tile_cntr,
    output logic           busy,
    output logic           last_col,
    output logic           last_row,
    output logic           last,
    output logic           done,
    output logic           cfg_err,
    output logic           state_dbg
);

    // Handshake: busy is the valid for the presented (col,row,tile) index and
    // advance is its ready. An index is consumed on a cycle with busy && advance;
    // on busy && !advance every counter and flag holds.

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state, state_next;
    logic [CCW-1:0] cols_q, cols_next;
    logic [RCW-1:0] rows_q, rows_next;
    logic [TCW-1:0] tiles_q, tiles_next;
    logic [CW-1:0]  col_next;
    logic [RW-1:0]  row_next;
    logic [TW-1:0]  tile_next;
    logic           done_next;
    logic           cfg_err_next;
    logic           cfg_ok;

    assign cfg_ok = (cfg_cols  != '0) && (cfg_cols  <= CCW'(MAX_COLS))  &&
                    (cfg_rows  != '0) && (cfg_rows  <= RCW'(MAX_ROWS))  &&
                    (cfg_tiles != '0) && (cfg_tiles <= TCW'(MAX_TILES));

    // Flags derive from the registered counters and latched bounds only, so they
    // are glitch-free with respect to advance and are forced low outside RUN.
    assign busy      = (state == RUN);
    assign last_col  = busy && (CCW'(col_cntr) == cols_q - CCW'(1));
    assign last_row  = last_col && (RCW'(row_cntr) == rows_q - RCW'(1));
    assign last      = last_row && (TCW'(tile_cntr) == tiles_q - TCW'(1));
    assign state_dbg = state;

    always_comb begin
        state_next   = state;
        cols_next    = cols_q;
        rows_next    = rows_q;
        tiles_next   = tiles_q;
        col_next     = col_cntr;
        row_next     = row_cntr;
        tile_next    = tile_cntr;
        done_next    = 1'b0;
        cfg_err_next = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        cols_next  = cfg_cols;
                        rows_next  = cfg_rows;
                        tiles_next = cfg_tiles;
                        state_next = RUN;
                    end else begin
                        cfg_err_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (advance) begin
                    if (last) begin
                        col_next   = '0;
                        row_next   = '0;
                        tile_next  = '0;
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else if (last_row) begin
                        col_next  = '0;
                        row_next  = '0;
                        tile_next = tile_cntr + TW'(1);
                    end else if (last_col) begin
                        col_next = '0;
                        row_next = row_cntr + RW'(1);
                    end else begin
                        col_next = col_cntr + CW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cols_q    <= '0;
            rows_q    <= '0;
            tiles_q   <= '0;
            col_cntr  <= '0;
            row_cntr  <= '0;
            tile_cntr <= '0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_next;
            cols_q    <= cols_next;
            rows_q    <= rows_next;
            tiles_q   <= tiles_next;
            col_cntr  <= col_next;
            row_cntr  <= row_next;
            tile_cntr <= tile_next;
            done      <= done_next;
            cfg_err   <= cfg_err_next;
        end
    end

endmodule
